// File: rtl/banyan_capture_seq.sv
`default_nettype none
// ============================================================================
// Module      : banyan_capture_seq
// Description : Capture sequencer for banyan_mem: arm, optional external
//               trigger with timeout, run to rollover, optional auto-rearm.
// Revision    : 1.0 - initial release
// ============================================================================
module banyan_capture_seq #(
    parameter int tw = 24,
    parameter int hw = 16
) (
    input  logic          adc_clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          abort,
    input  logic          mode_ext,
    input  logic          ext_trig,
    input  logic          auto_rearm,
    input  logic [hw-1:0] holdoff,
    input  logic [tw-1:0] timeout,
    input  logic          rollover,
    output logic          banyan_reset,
    output logic          banyan_run,
    output logic          busy,
    output logic          done,
    output logic          timeout_flag,
    output logic [2:0]    state,
    output logic [15:0]   capture_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_WAIT  = 3'd2,
        S_RUN   = 3'd3,
        S_HOLD  = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [tw-1:0] r_wait_cnt;
    logic [hw-1:0] r_hold_cnt;
    logic [15:0]   r_capture_count;
    logic          w_fin;
    logic          w_tmo;
    logic          w_accept;
    logic [tw-1:0] w_tmo_last;
    logic [hw:0]   w_hold_inc;

    assign w_tmo_last = timeout - tw'(1);
    assign w_hold_inc = {1'b0, r_hold_cnt} + (hw+1)'(1);

    always_comb begin
        w_next   = r_state;
        w_fin    = 1'b0;
        w_tmo    = 1'b0;
        w_accept = 1'b0;
        if (abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (arm) begin
                        w_next   = S_START;
                        w_accept = 1'b1;
                    end
                end
                S_START: w_next = mode_ext ? S_WAIT : S_RUN;
                S_WAIT: begin
                    // A trigger arriving on the final wait cycle still wins.
                    if (ext_trig) begin
                        w_next = S_RUN;
                    end else if ((timeout != '0) && (r_wait_cnt == w_tmo_last)) begin
                        w_next = S_IDLE;
                        w_tmo  = 1'b1;
                    end
                end
                S_RUN: begin
                    if (rollover) begin
                        w_fin = 1'b1;
                        if (!auto_rearm)
                            w_next = S_IDLE;
                        else if (holdoff != '0)
                            w_next = S_HOLD;
                        else
                            w_next = S_START;
                    end
                end
                S_HOLD: begin
                    // >= keeps the exit safe if holdoff shrinks mid-holdoff.
                    if (!auto_rearm)
                        w_next = S_IDLE;
                    else if (w_hold_inc >= {1'b0, holdoff})
                        w_next = S_START;
                end
                default: w_next = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge adc_clk or posedge rst) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_wait_cnt      <= '0;
            r_hold_cnt      <= '0;
            r_capture_count <= '0;
            banyan_reset    <= 1'b0;
            banyan_run      <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            timeout_flag    <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_wait_cnt   <= ((r_state == S_WAIT) && (w_next == S_WAIT)) ? r_wait_cnt + tw'(1) : '0;
            r_hold_cnt   <= ((r_state == S_HOLD) && (w_next == S_HOLD)) ? r_hold_cnt + hw'(1) : '0;
            banyan_reset <= (w_next == S_START);
            banyan_run   <= (w_next == S_RUN);
            busy         <= (w_next != S_IDLE);
            done         <= w_fin;
            if (w_fin)
                r_capture_count <= r_capture_count + 16'd1;
            if (w_accept)
                timeout_flag <= 1'b0;
            else if (w_tmo)
                timeout_flag <= 1'b1;
        end
    end

    assign state         = r_state;
    assign capture_count = r_capture_count;

endmodule
`default_nettype wire

// File: tb/tb_banyan_capture_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_banyan_capture_seq
// Description : Directed and randomized bench with a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banyan_capture_seq;

    localparam int TW = 24;
    localparam int HW = 16;

    logic          adc_clk = 1'b0;
    logic          rst = 1'b0;
    logic          arm = 1'b0;
    logic          abort = 1'b0;
    logic          mode_ext = 1'b0;
    logic          ext_trig = 1'b0;
    logic          auto_rearm = 1'b0;
    logic [HW-1:0] holdoff = '0;
    logic [TW-1:0] timeout = '0;
    logic          rollover = 1'b0;
    logic          banyan_reset;
    logic          banyan_run;
    logic          busy;
    logic          done;
    logic          timeout_flag;
    logic [2:0]    state;
    logic [15:0]   capture_count;

    int n_cmp = 0;
    int n_err = 0;

    // Model: phase code, cycles spent waiting, holdoff cycles left.
    int m_phase;
    int m_spent;
    int m_hold_left;
    int m_count;
    bit m_tflag;
    bit m_done;

    banyan_capture_seq #(.tw(TW), .hw(HW)) dut (
        .adc_clk       (adc_clk),
        .rst           (rst),
        .arm           (arm),
        .abort         (abort),
        .mode_ext      (mode_ext),
        .ext_trig      (ext_trig),
        .auto_rearm    (auto_rearm),
        .holdoff       (holdoff),
        .timeout       (timeout),
        .rollover      (rollover),
        .banyan_reset  (banyan_reset),
        .banyan_run    (banyan_run),
        .busy          (busy),
        .done          (done),
        .timeout_flag  (timeout_flag),
        .state         (state),
        .capture_count (capture_count)
    );

    always #5 adc_clk = ~adc_clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_phase     = 0;
        m_spent     = 0;
        m_hold_left = 0;
        m_count     = 0;
        m_tflag     = 1'b0;
        m_done      = 1'b0;
    endfunction

    function automatic void model_step();
        m_done = 1'b0;
        if (abort) begin
            m_phase = 0;
        end else begin
            case (m_phase)
                0: if (arm) begin m_phase = 1; m_tflag = 1'b0; end
                1: begin
                    if (mode_ext) begin m_phase = 2; m_spent = 0; end
                    else m_phase = 3;
                end
                2: begin
                    if (ext_trig) m_phase = 3;
                    else begin
                        m_spent++;
                        if (timeout != 0 && m_spent == int'(timeout)) begin
                            m_phase = 0;
                            m_tflag = 1'b1;
                        end
                    end
                end
                3: begin
                    if (rollover) begin
                        m_done  = 1'b1;
                        m_count = (m_count + 1) % 65536;
                        if (!auto_rearm) m_phase = 0;
                        else if (holdoff != 0) begin m_phase = 4; m_hold_left = int'(holdoff); end
                        else m_phase = 1;
                    end
                end
                4: begin
                    if (!auto_rearm) m_phase = 0;
                    else begin
                        m_hold_left--;
                        if (m_hold_left == 0) m_phase = 1;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    endfunction

    task automatic compare_model();
        check_val("state", 32'(state), m_phase);
        check_val("banyan_reset", 32'(banyan_reset), 32'(m_phase == 1));
        check_val("banyan_run", 32'(banyan_run), 32'(m_phase == 3));
        check_val("busy", 32'(busy), 32'(m_phase != 0));
        check_val("done", 32'(done), 32'(m_done));
        check_val("timeout_flag", 32'(timeout_flag), 32'(m_tflag));
        check_val("capture_count", 32'(capture_count), m_count);
    endtask

    task automatic tick();
        @(posedge adc_clk);
        model_step();
        #1;
        compare_model();
    endtask

    initial begin
        model_reset();
        #1 rst = 1'b1;
        @(posedge adc_clk);
        #1;
        compare_model();
        check_val("rst_state", 32'(state), 0);
        check_val("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        repeat (3) tick();

        // Immediate capture
        arm = 1'b1; tick(); arm = 1'b0;
        check_val("imm_start_reset", 32'(banyan_reset), 1);
        tick();
        check_val("imm_run", 32'(banyan_run), 1);
        repeat (27) tick();
        rollover = 1'b1; tick(); rollover = 1'b0;
        check_val("imm_done", 32'(done), 1);
        check_val("imm_count", 32'(capture_count), 1);
        check_val("imm_idle", 32'(state), 0);

        // Triggered capture with timeout
        mode_ext = 1'b1; timeout = 5;
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        repeat (4) tick();
        check_val("tmo_still_wait", 32'(state), 2);
        tick();
        check_val("tmo_flag", 32'(timeout_flag), 1);
        check_val("tmo_idle", 32'(state), 0);
        arm = 1'b1; tick(); arm = 1'b0;
        check_val("tmo_flag_clr", 32'(timeout_flag), 0);
        tick(); tick(); tick();
        ext_trig = 1'b1; tick(); ext_trig = 1'b0;
        check_val("trig_run", 32'(banyan_run), 1);
        check_val("trig_noflag", 32'(timeout_flag), 0);
        rollover = 1'b1; tick(); rollover = 1'b0;

        // Auto-rearm with and without holdoff
        mode_ext = 1'b0; auto_rearm = 1'b1; holdoff = 3;
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        rollover = 1'b1; tick(); rollover = 1'b0;
        check_val("hold_enter", 32'(state), 4);
        tick(); tick();
        check_val("hold_third", 32'(state), 4);
        tick();
        check_val("hold_restart", 32'(banyan_reset), 1);
        holdoff = 0;
        tick();
        rollover = 1'b1; tick(); rollover = 1'b0;
        check_val("hold0_start", 32'(state), 1);
        auto_rearm = 1'b0;
        abort = 1'b1; tick(); abort = 1'b0;
        check_val("abort_idle", 32'(busy), 0);

        // Priority
        arm = 1'b1; abort = 1'b1; tick(); arm = 1'b0; abort = 1'b0;
        check_val("arm_abort", 32'(state), 0);
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        abort = 1'b1; tick(); abort = 1'b0;
        check_val("abort_run", 32'(banyan_run), 0);
        check_val("abort_count", 32'(capture_count), 4);

        // Rollover outside RUN
        rollover = 1'b1; tick(); rollover = 1'b0;
        check_val("roll_idle", 32'(capture_count), 4);
        mode_ext = 1'b1; timeout = 0;
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        rollover = 1'b1; repeat (3) tick(); rollover = 1'b0;
        check_val("roll_wait", 32'(state), 2);
        ext_trig = 1'b1; tick(); ext_trig = 1'b0;

        // Asynchronous reset mid-RUN
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare_model();
        check_val("rst_run_off", 32'(banyan_run), 0);
        @(posedge adc_clk);
        #1 rst = 1'b0;
        repeat (2) tick();

        // Counter wrap
        force dut.r_capture_count = 16'hFFFF;
        #1 release dut.r_capture_count;
        m_count = 65535;
        check_val("wrap_pre", 32'(capture_count), 32'h0000FFFF);
        mode_ext = 1'b0;
        arm = 1'b1; tick(); arm = 1'b0;
        tick();
        rollover = 1'b1; tick(); rollover = 1'b0;
        check_val("wrap_zero", 32'(capture_count), 0);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            arm      = ($urandom_range(3) == 0);
            abort    = ($urandom_range(39) == 0);
            ext_trig = ($urandom_range(5) == 0);
            rollover = ($urandom_range(7) == 0);
            mode_ext = 1'($urandom_range(1));
            if ($urandom_range(15) == 0) auto_rearm = ~auto_rearm;
            if (m_phase == 0) begin
                timeout = TW'($urandom_range(6));
                holdoff = HW'($urandom_range(4));
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
